// File: rtl/weight_port_arbiter.sv
`default_nettype none
// ============================================================================
// weight_port_arbiter
//   Round-robin burst arbiter sharing the weight/bias memory read port.
//   Revision: 1.0
// ============================================================================
module weight_port_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int N_REQ       = 4,
  parameter int LEN_WIDTH   = 10,
  parameter int MEM_LATENCY = 1
) (
  input  logic                             clock_i,
  input  logic                             reset_i,
  input  logic [N_REQ-1:0]                 req_i,
  input  logic [N_REQ-1:0][ADDR_WIDTH-1:0] base_addr_i,
  input  logic [N_REQ-1:0][LEN_WIDTH-1:0]  len_i,
  input  logic [DATA_WIDTH-1:0]            mem_data_i,
  output logic [ADDR_WIDTH-1:0]            mem_rdaddress_o,
  output logic [DATA_WIDTH-1:0]            data_o,
  output logic [N_REQ-1:0]                 data_valid_o,
  output logic [N_REQ-1:0]                 grant_o,
  output logic [N_REQ-1:0]                 done_o
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDX_W-1:0] c_LAST_INIT = IDX_W'(N_REQ - 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ISSUE = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;

  logic [1:0]             r_state;
  logic [IDX_W-1:0]       r_owner;
  logic [IDX_W-1:0]       r_last_grant;
  logic [LEN_WIDTH-1:0]   r_remaining;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [N_REQ-1:0]       r_grant;
  logic [N_REQ-1:0]       r_done;
  logic [MEM_LATENCY-1:0] r_issue_pipe;

  logic [MEM_LATENCY-1:0] w_pipe_next;
  logic                   w_shift_in;
  logic                   w_pipe_out;
  logic [IDX_W-1:0]       w_winner;
  logic [N_REQ-1:0]       w_winner_onehot;
  logic [N_REQ-1:0]       w_owner_onehot;

  // Scan starts just after the previous winner, so it gets lowest priority.
  always_comb begin
    int               idx;
    logic             found;
    logic [IDX_W-1:0] cand;
    idx      = 0;
    found    = 1'b0;
    cand     = '0;
    w_winner = r_last_grant;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(r_last_grant) + 1 + i;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      cand = IDX_W'(idx);
      if (!found && req_i[cand]) begin
        found    = 1'b1;
        w_winner = cand;
      end
    end
  end

  assign w_shift_in = (r_state == c_ISSUE);
  assign w_pipe_out = r_issue_pipe[MEM_LATENCY-1];

  if (MEM_LATENCY == 1) begin : g_pipe_single
    assign w_pipe_next = w_shift_in;
  end else begin : g_pipe_multi
    assign w_pipe_next = {r_issue_pipe[MEM_LATENCY-2:0], w_shift_in};
  end

  for (genvar n = 0; n < N_REQ; n++) begin : g_onehot
    assign w_winner_onehot[n] = (w_winner == IDX_W'(n));
    assign w_owner_onehot[n]  = (r_owner == IDX_W'(n));
    assign data_valid_o[n]    = w_pipe_out & w_owner_onehot[n];
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state      <= c_IDLE;
      r_owner      <= '0;
      r_last_grant <= c_LAST_INIT;
      r_remaining  <= '0;
      r_addr       <= '0;
      r_grant      <= '0;
      r_done       <= '0;
      r_issue_pipe <= '0;
    end else begin
      r_done       <= '0;
      r_issue_pipe <= w_pipe_next;
      case (r_state)
        c_IDLE: begin
          if (|req_i) begin
            r_owner      <= w_winner;
            r_last_grant <= w_winner;
            r_remaining  <= len_i[w_winner];
            r_addr       <= base_addr_i[w_winner];
            if (len_i[w_winner] == '0) begin
              r_done <= w_winner_onehot;
            end else begin
              r_grant <= w_winner_onehot;
              r_state <= c_ISSUE;
            end
          end
        end
        c_ISSUE: begin
          r_remaining <= r_remaining - LEN_WIDTH'(1);
          if (r_remaining > LEN_WIDTH'(1)) begin
            r_addr <= r_addr + ADDR_WIDTH'(1);
          end else begin
            r_state <= c_DRAIN;
          end
        end
        c_DRAIN: begin
          // Release as the last word leaves the pipeline, not a cycle later.
          if (w_pipe_next == '0) begin
            r_grant <= '0;
            r_done  <= w_owner_onehot;
            r_state <= c_IDLE;
          end
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign mem_rdaddress_o = r_addr;
  assign data_o          = mem_data_i;
  assign grant_o         = r_grant;
  assign done_o          = r_done;

endmodule
`default_nettype wire

// File: tb/tb_weight_port_arbiter.sv
`default_nettype none
// Directed bursts on an MEM_LATENCY=1 instance (a) and an MEM_LATENCY=3 instance (b);
// expected words and cycle stamps are queued at stimulus time and popped by a monitor.
module tb_weight_port_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int NR = 4;
  localparam int LW = 10;

  logic clock_i = 1'b0;
  logic reset_i = 1'b0;
  always #5 clock_i = ~clock_i;

  int cyc = 0;
  always @(posedge clock_i) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [NR-1:0]         req_a, req_b;
  logic [NR-1:0][AW-1:0] base_a, base_b;
  logic [NR-1:0][LW-1:0] len_a, len_b;
  logic [DW-1:0]         mem_a;
  logic [DW-1:0]         mem_b_pipe [3];
  logic [AW-1:0]         addr_a, addr_b;
  logic [DW-1:0]         data_a, data_b;
  logic [NR-1:0]         dv_a, dv_b, grant_a, grant_b, done_a, done_b;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a ^ 16'hC3A5, a};
  endfunction

  always @(posedge clock_i) begin
    mem_a         <= mem_word(addr_a);
    mem_b_pipe[0] <= mem_word(addr_b);
    mem_b_pipe[1] <= mem_b_pipe[0];
    mem_b_pipe[2] <= mem_b_pipe[1];
  end

  weight_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_REQ(NR), .LEN_WIDTH(LW), .MEM_LATENCY(1)
  ) dut_a (
    .clock_i(clock_i), .reset_i(reset_i), .req_i(req_a), .base_addr_i(base_a),
    .len_i(len_a), .mem_data_i(mem_a), .mem_rdaddress_o(addr_a), .data_o(data_a),
    .data_valid_o(dv_a), .grant_o(grant_a), .done_o(done_a)
  );

  weight_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_REQ(NR), .LEN_WIDTH(LW), .MEM_LATENCY(3)
  ) dut_b (
    .clock_i(clock_i), .reset_i(reset_i), .req_i(req_b), .base_addr_i(base_b),
    .len_i(len_b), .mem_data_i(mem_b_pipe[2]), .mem_rdaddress_o(addr_b), .data_o(data_b),
    .data_valid_o(dv_b), .grant_o(grant_b), .done_o(done_b)
  );

  typedef struct {
    bit            is_done;
    int            req;
    logic [DW-1:0] data;
    int            cyc;
  } ev_t;

  ev_t q_a[$];
  ev_t q_b[$];

  function automatic int q_size(input int which);
    return (which == 0) ? q_a.size() : q_b.size();
  endfunction

  function automatic ev_t q_front(input int which);
    return (which == 0) ? q_a[0] : q_b[0];
  endfunction

  task automatic push_ev(input int which, input ev_t e);
    if (which == 0) q_a.push_back(e);
    else            q_b.push_back(e);
  endtask

  task automatic pop_ev(input int which, output ev_t e);
    if (which == 0) e = q_a.pop_front();
    else            e = q_b.pop_front();
  endtask

  // Winner sampled in cycle k: words at k+1+ml .. k+len+ml, done at k+len+ml+1.
  task automatic expect_burst(input int which, input int n, input logic [AW-1:0] base,
                              input int len, input int k, input int ml);
    ev_t           e;
    logic [AW-1:0] a;
    for (int i = 0; i < len; i++) begin
      a         = base + AW'(i);
      e.is_done = 1'b0;
      e.req     = n;
      e.data    = mem_word(a);
      e.cyc     = k + 1 + ml + i;
      push_ev(which, e);
    end
    e.is_done = 1'b1;
    e.req     = n;
    e.data    = '0;
    e.cyc     = (len == 0) ? k + 1 : k + len + ml + 1;
    push_ev(which, e);
  endtask

  task automatic check_cycle(input int which, input logic [NR-1:0] dv, input logic [NR-1:0] gr,
                             input logic [NR-1:0] dn, input logic [DW-1:0] data);
    ev_t           e;
    logic [NR-1:0] one;
    logic [NR-1:0] oh;
    one = 4'b0001;
    if (dv != '0) begin
      checks++;
      if (q_size(which) == 0) begin
        errors++;
        $display("FAIL dut%0d unexpected_word: got dv=%b data=%h at cyc %0d, required no word",
                 which, dv, data, cyc);
      end else begin
        pop_ev(which, e);
        oh = one << e.req;
        if (e.is_done || dv != oh || gr != oh || data != e.data || cyc != e.cyc) begin
          errors++;
          $display("FAIL dut%0d data_word: got dv=%b grant=%b data=%h cyc=%0d, required dv=%b grant=%b data=%h cyc=%0d done_ev=%0d",
                   which, dv, gr, data, cyc, oh, oh, e.data, e.cyc, e.is_done);
        end
      end
    end
    if (dn != '0) begin
      checks++;
      if (q_size(which) == 0) begin
        errors++;
        $display("FAIL dut%0d unexpected_done: got done=%b at cyc %0d, required none", which, dn, cyc);
      end else begin
        pop_ev(which, e);
        oh = one << e.req;
        if (!e.is_done || dn != oh || gr != '0 || cyc != e.cyc) begin
          errors++;
          $display("FAIL dut%0d done_pulse: got done=%b grant=%b cyc=%0d, required done=%b grant=0000 cyc=%0d",
                   which, dn, gr, cyc, oh, e.cyc);
        end
      end
    end
    while (q_size(which) > 0 && q_front(which).cyc <= cyc) begin
      pop_ev(which, e);
      checks++;
      errors++;
      $display("FAIL dut%0d missing_event: got nothing at cyc %0d, required req%0d done_ev=%0d data=%h",
               which, e.cyc, e.req, e.is_done, e.data);
    end
  endtask

  always @(negedge clock_i) begin
    if (!reset_i) begin
      check_cycle(0, dv_a, grant_a, done_a, data_a);
      check_cycle(1, dv_b, grant_b, done_b, data_b);
      checks++;
      if (!$onehot0(grant_a) || !$onehot0(grant_b)) begin
        errors++;
        $display("FAIL grant_onehot: got grant_a=%b grant_b=%b, required at most one bit each",
                 grant_a, grant_b);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic wait_cycle(input int t);
    while (cyc < t) @(negedge clock_i);
  endtask

  initial begin
    int c;
    int r;
    ev_t e;
    req_a  = '0; base_a = '0; len_a = '0;
    req_b  = '0; base_b = '0; len_b = '0;
    #1 reset_i = 1'b1;
    @(negedge clock_i);
    chk("reset_grant_a", 32'(grant_a), 32'h0);
    chk("reset_valid_a", 32'(dv_a), 32'h0);
    chk("reset_done_a",  32'(done_a), 32'h0);
    chk("reset_addr_a",  32'(addr_a), 32'h0);
    chk("reset_grant_b", 32'(grant_b), 32'h0);
    chk("reset_addr_b",  32'(addr_b), 32'h0);
    @(negedge clock_i);
    reset_i = 1'b0;
    repeat (2) @(negedge clock_i);

    // Single burst on requester 0.
    c = cyc;
    base_a[0] = 16'h0010; len_a[0] = 10; req_a[0] = 1'b1;
    expect_burst(0, 0, 16'h0010, 10, c, 1);
    wait_cycle(c + 12); req_a[0] = 1'b0;
    repeat (2) @(negedge clock_i);

    // Zero-length burst on requester 3.
    c = cyc;
    base_a[3] = 16'h0ABC; len_a[3] = 0; req_a[3] = 1'b1;
    expect_burst(0, 3, 16'h0ABC, 0, c, 1);
    wait_cycle(c + 1); req_a[3] = 1'b0;
    repeat (2) @(negedge clock_i);

    // Round robin, everyone requesting continuously: 0,1,2,3,0 back to back.
    c = cyc;
    for (int n = 0; n < NR; n++) begin
      base_a[n] = 16'h0100 * 16'(n + 1);
      len_a[n]  = 3;
    end
    req_a = '1;
    expect_burst(0, 0, 16'h0100, 3, c,      1);
    expect_burst(0, 1, 16'h0200, 3, c + 5,  1);
    expect_burst(0, 2, 16'h0300, 3, c + 10, 1);
    expect_burst(0, 3, 16'h0400, 3, c + 15, 1);
    expect_burst(0, 0, 16'h0100, 3, c + 20, 1);
    wait_cycle(c + 21); req_a = '0;
    wait_cycle(c + 27);

    // Address wrap at the top of memory.
    c = cyc;
    base_a[2] = 16'hFFFE; len_a[2] = 4; req_a[2] = 1'b1;
    expect_burst(0, 2, 16'hFFFE, 4, c, 1);
    wait_cycle(c + 6); req_a[2] = 1'b0;
    repeat (2) @(negedge clock_i);

    // Inputs change mid-burst; the sampled base/len must stick.
    c = cyc;
    base_a[1] = 16'h0200; len_a[1] = 4; req_a[1] = 1'b1;
    expect_burst(0, 1, 16'h0200, 4, c, 1);
    wait_cycle(c + 2);
    base_a[1] = 16'h3333; len_a[1] = 7; req_a[1] = 1'b0;
    wait_cycle(c + 8);

    // Reset during requester 2's burst, after two words have come out.
    c = cyc;
    base_a[2] = 16'h0400; len_a[2] = 8; req_a[2] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      e.is_done = 1'b0; e.req = 2; e.data = mem_word(16'h0400 + 16'(i)); e.cyc = c + 2 + i;
      push_ev(0, e);
    end
    wait_cycle(c + 3);
    #2 reset_i = 1'b1;
    #1;
    chk("midreset_grant", 32'(grant_a), 32'h0);
    chk("midreset_valid", 32'(dv_a), 32'h0);
    chk("midreset_done",  32'(done_a), 32'h0);
    chk("midreset_addr",  32'(addr_a), 32'h0);
    base_a[0] = 16'h0500; len_a[0] = 2;
    base_a[2] = 16'h0600; len_a[2] = 3;
    req_a = 4'b0101;
    repeat (2) @(negedge clock_i);
    reset_i = 1'b0;
    r = cyc;
    expect_burst(0, 0, 16'h0500, 2, r,     1);
    expect_burst(0, 2, 16'h0600, 3, r + 4, 1);
    wait_cycle(r + 4); req_a[0] = 1'b0;
    wait_cycle(r + 9); req_a[2] = 1'b0;
    repeat (2) @(negedge clock_i);

    // Latency 3 instance.
    c = cyc;
    base_b[1] = 16'h0700; len_b[1] = 5; req_b[1] = 1'b1;
    expect_burst(1, 1, 16'h0700, 5, c, 3);
    wait_cycle(c + 9); req_b[1] = 1'b0;
    repeat (3) @(negedge clock_i);

    for (int i = 0; i < 50 && (q_a.size() + q_b.size()) > 0; i++) @(negedge clock_i);
    while (q_a.size() > 0) begin
      e = q_a.pop_front(); checks++; errors++;
      $display("FAIL dut0 leftover_event: got nothing, required req%0d at cyc %0d", e.req, e.cyc);
    end
    while (q_b.size() > 0) begin
      e = q_b.pop_front(); checks++; errors++;
      $display("FAIL dut1 leftover_event: got nothing, required req%0d at cyc %0d", e.req, e.cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
